// File: rtl/receiver_spi.sv
// receiver_spi
//   Receive-side capture stage. A level strobe (new_sig) from an unrelated
//   clock domain is synchronized into clk. On its synchronized rising edge
//   the parallel word in_sig is captured. sig_alert is then held high for as
//   long as the synchronized strobe stays high.
//
//   Params : SYNC_STAGES - synchronizer depth, legal range 2..4
//            WIDTH       - data word width
//   Ports  : clk           - the only clock
//            rst_n         - asynchronous active-low reset, clears all state
//            new_sig       - async level strobe from the source
//            in_sig        - data word, held stable by the source protocol
//            processed_sig - last captured word, held until the next capture
//            sig_alert     - high exactly while the FSM is in ALERT
module receiver_spi #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             new_sig,
  input  logic [WIDTH-1:0] in_sig,
  output logic [WIDTH-1:0] processed_sig,
  output logic             sig_alert
);

  typedef enum logic {IDLE = 1'b0, ALERT = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   strobe_s, strobe_d;
  logic                   rise;
  logic                   capture;

  // Strobe synchronizer. in_sig is deliberately not synchronized. The source
  // holds it stable across the strobe latency, so the word is quiet by the
  // time the capture edge arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe <= '0;
      strobe_d  <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], new_sig};
      strobe_d  <= strobe_s;
    end
  end

  assign strobe_s = sync_pipe[SYNC_STAGES-1];
  assign rise     = strobe_s & ~strobe_d;

  // State register and data holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      processed_sig <= '0;
    end else begin
      state_q <= state_d;
      if (capture) processed_sig <= in_sig;
    end
  end

  // Next state. A capture happens only on the transition out of IDLE. Words
  // that appear while in ALERT are therefore ignored until the strobe drops.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = ALERT;
          capture = 1'b1;
        end
      end
      ALERT: begin
        if (!strobe_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sig_alert = (state_q == ALERT);

endmodule

// File: tb/tb_receiver_spi.sv
// tb_receiver_spi
//   Directed bench for receiver_spi with default parameters (SYNC_STAGES=2).
//   Inputs are driven just after the falling edge. Outputs are sampled on the
//   falling edge. A strobe first sampled at rising edge k is therefore seen as
//   captured at the third falling edge after it is driven.
module tb_receiver_spi;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             new_sig;
  logic [WIDTH-1:0] in_sig;
  logic [WIDTH-1:0] processed_sig;
  logic             sig_alert;

  int n_checks = 0;
  int n_fail   = 0;

  receiver_spi #(.SYNC_STAGES(2), .WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .new_sig       (new_sig),
    .in_sig        (in_sig),
    .processed_sig (processed_sig),
    .sig_alert     (sig_alert)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise the strobe with a word, then check the exact capture latency.
  task automatic strobe_on(input string tag, input logic [31:0] w);
    in_sig  = w;
    new_sig = 1'b1;
    tick(2);
    chk({tag, "_alert_pre"}, {31'b0, sig_alert}, 32'd0);
    tick(1);
    chk({tag, "_alert"}, {31'b0, sig_alert}, 32'd1);
    chk({tag, "_data"}, processed_sig, w);
  endtask

  // Drop the strobe and check the exact release latency and data hold.
  task automatic strobe_off(input string tag, input logic [31:0] w);
    new_sig = 1'b0;
    tick(2);
    chk({tag, "_rel_pre"}, {31'b0, sig_alert}, 32'd1);
    tick(1);
    chk({tag, "_rel"}, {31'b0, sig_alert}, 32'd0);
    chk({tag, "_hold"}, processed_sig, w);
    tick(2);
  endtask

  initial begin
    rst_n   = 1'b0;
    new_sig = 1'b1;
    in_sig  = 32'hFFFF_FFFF;

    // Reset dominates while the strobe and data are active.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_data", processed_sig, 32'h0);
      chk("rst_alert", {31'b0, sig_alert}, 32'd0);
    end
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_pre", {31'b0, sig_alert}, 32'd0);
    tick(1);
    chk("post_rst_alert", {31'b0, sig_alert}, 32'd1);
    chk("post_rst_data", processed_sig, 32'hFFFF_FFFF);
    strobe_off("post_rst", 32'hFFFF_FFFF);

    // Basic capture.
    strobe_on("basic", 32'd50000);
    tick(2);
    strobe_off("basic", 32'd50000);

    // Second word, with the strobe held high for 7 clocks.
    strobe_on("second", 32'd32);
    tick(4);
    chk("second_held", processed_sig, 32'd32);
    strobe_off("second", 32'd32);

    // A data change in the middle of the strobe is ignored.
    strobe_on("midchg", 32'h1234_5678);
    in_sig = 32'hDEAD_BEEF;
    tick(3);
    chk("midchg_keep", processed_sig, 32'h1234_5678);
    chk("midchg_alert", {31'b0, sig_alert}, 32'd1);
    strobe_off("midchg", 32'h1234_5678);

    // Single-clock pulse. The capture itself is optional, but the alert
    // must be clear again within SYNC_STAGES+1 clocks.
    in_sig  = 32'd7;
    new_sig = 1'b1;
    tick(1);
    new_sig = 1'b0;
    tick(5);
    chk("short_alert", {31'b0, sig_alert}, 32'd0);

    // Reset in the middle of a strobe clears the outputs at once. The strobe
    // is still high, so it is re-captured 3 clocks after release.
    strobe_on("rstmid", 32'hA5A5_A5A5);
    rst_n = 1'b0;
    #1;
    chk("rstmid_clr_data", processed_sig, 32'h0);
    chk("rstmid_clr_alert", {31'b0, sig_alert}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("rstmid_re_pre", {31'b0, sig_alert}, 32'd0);
    tick(1);
    chk("rstmid_re_alert", {31'b0, sig_alert}, 32'd1);
    chk("rstmid_re_data", processed_sig, 32'hA5A5_A5A5);
    strobe_off("rstmid", 32'hA5A5_A5A5);

    // Capture an all-zero word, then hold the strobe high for a long time.
    // There must be one capture, and the alert must stay high.
    strobe_on("zero", 32'h0);
    in_sig = 32'h5555_AAAA;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("hold_alert", {31'b0, sig_alert}, 32'd1);
    end
    chk("hold_data", processed_sig, 32'h0);
    strobe_off("zero", 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/receiver_spi.md
# receiver_spi

Receive-side capture stage for the interconnect network. It samples a 32-bit parallel word `in_sig` from an asynchronous or unrelated source when the source raises the strobe `new_sig`. The strobe is synchronized into the local `clk` domain and the word is captured on its synchronized rising edge. The block presents the held word on `processed_sig` and raises the level flag `sig_alert` for as long as the strobe stays asserted. Downstream consumers read `processed_sig` while `sig_alert` is high.

## Interface
- `SYNC_STAGES`, default 2: number of flip-flops in the `new_sig` synchronizer chain; legal values are 2 to 4.
- `WIDTH`, default 32: width of the data word.
- `clk`  input  1: the only clock; all state changes on its rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low; it clears all state immediately.
- `new_sig`  input  1: strobe from the source; level-sensitive and asynchronous to `clk`.
- `in_sig`  input  WIDTH: data word; the source holds it stable from before `new_sig` rises until after `new_sig` falls.
- `processed_sig`  output  WIDTH: the most recently captured word, held until the next capture.
- `sig_alert`  output  1: high while a captured word is current and the synchronized strobe is still high.

## Operation
- **Synchronizer.** `new_sig` passes through a chain of SYNC_STAGES flops, giving `strobe_s`. A further flop gives `strobe_d`.
- **Rise detection.** `rise = strobe_s & ~strobe_d`.
- **Capture.** On the clock edge where `rise` is 1, the block does two things:
  - loads `in_sig` into the `processed_sig` register;
  - sets `sig_alert` to 1.
- **Hold.** While `strobe_s` stays 1, `sig_alert` stays 1 and `processed_sig` does not change. Changes on `in_sig` during this time are ignored.
- **Release.** On the first clock edge where `strobe_s` is 0, `sig_alert` goes to 0. `processed_sig` keeps its value.
- **`in_sig` is never synchronized bit-by-bit.** Its stability is guaranteed by the source protocol and the strobe latency.
- **State machine.** Two states, IDLE and ALERT:
  - IDLE → ALERT on `rise`, capturing the word.
  - ALERT → IDLE when `strobe_s` is 0.
  - `sig_alert` is 1 exactly in ALERT.
- **Reset values.** `processed_sig` = 0, `sig_alert` = 0, all synchronizer and delay flops = 0, state = IDLE.
- **Boundary conditions:**
  - A strobe high for fewer than SYNC_STAGES+1 clocks may be missed. Strobes of at least that length are always captured.
  - A strobe low gap of fewer than SYNC_STAGES+1 clocks may merge two strobes into one. In that case the first word is kept.
  - A capture of an all-zero word is legal. It is distinguished from reset only by `sig_alert`.
  - If `rst_n` is asserted mid-strobe, everything clears at once. After release, a strobe that is still high is seen as a new rise and is re-captured.
  - `new_sig` held high forever: one capture, and `sig_alert` stays high.

## Timing
- Let edge k be the first rising edge of `clk` that samples `new_sig` = 1.
- `strobe_s` = 1 after edge k+SYNC_STAGES−1.
- Capture happens on edge k+SYNC_STAGES. With the default SYNC_STAGES = 2, `processed_sig` and `sig_alert` are valid after edge k+2, a latency of 3 sampling edges.
- Deassert latency is symmetric. If edge j is the first edge sampling `new_sig` = 0, then `sig_alert` = 0 after edge j+SYNC_STAGES.
- Outputs are registered. There is no combinational path from any input to any output.
- The source must meet two rules:
  - hold `in_sig` stable for at least SYNC_STAGES+2 clocks after raising `new_sig`;
  - set up `in_sig` no later than the `new_sig` rise.

## Test plan
- **Reset.** Hold `rst_n` = 0 with `in_sig` = 0xFFFFFFFF and `new_sig` = 1 → `processed_sig` = 0 and `sig_alert` = 0 throughout. After release → capture of 0xFFFFFFFF within 3 clocks.
- **Basic capture.** `in_sig` = 50000, `new_sig` = 1 for 4+ clocks → within 4 clocks `sig_alert` = 1 and `processed_sig` = 50000. Drop `new_sig` → `sig_alert` = 0 within 4 clocks and `processed_sig` remains 50000.
- **Second word.** After the basic-capture sequence, `in_sig` = 32, `new_sig` = 1 for 7 clocks → `sig_alert` = 1 and `processed_sig` = 32. Drop `new_sig` → `sig_alert` = 0 and `processed_sig` remains 32.
- **Data change mid-strobe.** Capture 0x12345678, then change `in_sig` to 0xDEADBEEF while `new_sig` is still high → `processed_sig` stays 0x12345678.
- **Short pulse.** `new_sig` high for a single clock with `in_sig` = 7 → no requirement on capture. If a capture does occur, `sig_alert` must return to 0 within SYNC_STAGES+1 clocks.
- **Reset mid-strobe.** During ALERT, pulse `rst_n` low for 1 clock while `new_sig` stays 1 → outputs clear immediately. The word is re-captured 3 clocks after release.
